// File: rtl/ibex_regfile_msg_pkg.sv
// Shared types and sizing helpers for the burst message-ingress register file.
// Contents: ingress FSM state enum, address/length width helpers, error causes.
package ibex_regfile_msg_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } msg_state_e;

   // Error causes; any cause other than ErrNone raises the err pulse.
   localparam logic [1:0] ErrNone    = 2'd0;
   localparam logic [1:0] ErrLen     = 2'd1;
   localparam logic [1:0] ErrPending = 2'd2;

   function automatic int unsigned addr_width(input bit rv32e);
      return rv32e ? 4 : 5;
   endfunction

   function automatic int unsigned num_words(input bit rv32e);
      return rv32e ? 16 : 32;
   endfunction

   function automatic int unsigned len_width(input int unsigned max_burst);
      return $clog2(max_burst) + 1;
   endfunction

endpackage

// File: rtl/ibex_regfile_msg_seq.sv
// Message-ingress sequencer: accepts 1..MaxBurst beats over valid/ready and
// turns each accepted beat into a one-hot register write strobe plus data.
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   we_a_i, waddr_a_i        core write port (for conflict/stall detection)
//   msg_valid_i/ready_o      ingress handshake (ready is combinational)
//   msg_addr_i, msg_len_i    start register and length, used on first beat
//   msg_data_i               beat data
//   msg_busy_o/done_o/err_o  status (busy from state, done/err registered)
//   msg_we_o, msg_wdata_o    one-hot register write strobe and data
//   msg_pending_o            reservation bitmap (IBEX_REGFILE_MSG_SCOREBOARD_EN)
module ibex_regfile_msg_seq
   import ibex_regfile_msg_pkg::*;
#(
   parameter bit          RV32E     = 1'b0,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned MaxBurst  = 4
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              we_a_i,
   input  logic [4:0]                        waddr_a_i,
   input  logic                              msg_valid_i,
   output logic                              msg_ready_o,
   input  logic [4:0]                        msg_addr_i,
   input  logic [len_width(MaxBurst)-1:0]    msg_len_i,
   input  logic [DataWidth-1:0]              msg_data_i,
   output logic                              msg_busy_o,
   output logic                              msg_done_o,
   output logic                              err_o,
   output logic [num_words(RV32E)-1:0]       msg_we_o,
   output logic [DataWidth-1:0]              msg_wdata_o
`ifdef IBEX_REGFILE_MSG_SCOREBOARD_EN
   ,
   output logic [num_words(RV32E)-1:0]       msg_pending_o
`endif
);

   localparam int unsigned AW = addr_width(RV32E);
   localparam int unsigned NW = num_words(RV32E);
   localparam int unsigned LW = len_width(MaxBurst);

   msg_state_e    state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [LW-1:0] rem_q, rem_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic [1:0]    err_cause;
   logic [AW-1:0] target;
   logic [AW-1:0] waddr;
   logic          conflict;
   logic          accept;
   logic          len_bad;
   logic          beat_we;
   logic          pend_hit;

   // Current write target: the start address on a first beat, else the pointer.
   assign waddr    = waddr_a_i[AW-1:0];
   assign target   = (state_q == IDLE) ? msg_addr_i[AW-1:0] : ptr_q;

   // Core write wins a same-register collision; x0 writes are dropped so never stall.
   assign conflict    = we_a_i && (waddr == target) && (target != '0);
   assign msg_ready_o = ~conflict;
   assign accept      = msg_valid_i && msg_ready_o;
   assign len_bad     = (msg_len_i == '0) || (msg_len_i > LW'(MaxBurst));

   // Next-state, counters and status pulses.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      rem_d     = rem_q;
      done_d    = 1'b0;
      err_cause = ErrNone;
      beat_we   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               if (len_bad) begin
                  err_cause = ErrLen;
               end else begin
                  beat_we = 1'b1;
                  if (msg_len_i == LW'(1)) begin
                     done_d = 1'b1;
                  end else begin
                     state_d = BURST;
                     ptr_d   = target + AW'(1);
                     rem_d   = msg_len_i - LW'(1);
                  end
               end
            end
         end
         BURST: begin
            if (accept) begin
               beat_we = 1'b1;
               ptr_d   = ptr_q + AW'(1);
               rem_d   = rem_q - LW'(1);
               if (rem_q == LW'(1)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (pend_hit) begin
         err_cause = ErrPending;
      end
   end

   assign err_d = (err_cause != ErrNone);

   // State and counter registers.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         rem_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         rem_q   <= rem_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign msg_busy_o  = (state_q == BURST);
   assign msg_done_o  = done_q;
   assign err_o       = err_q;
   assign msg_we_o    = (beat_we && (target != '0)) ? (NW'(1) << target) : '0;
   assign msg_wdata_o = msg_data_i;

`ifdef IBEX_REGFILE_MSG_SCOREBOARD_EN
   logic [NW-1:0] pend_q, pend_d;
   logic [AW-1:0] pidx;

   // Reserve the rest of the burst on the first beat; release each slot as written.
   always_comb begin
      pend_d = pend_q;
      pidx   = '0;
      if (beat_we && (state_q == BURST)) begin
         pend_d[ptr_q] = 1'b0;
      end
      if (beat_we && (state_q == IDLE)) begin
         for (int unsigned k = 1; k < MaxBurst; k++) begin
            pidx = target + AW'(k);
            if ((LW'(k) < msg_len_i) && (pidx != '0)) begin
               pend_d[pidx] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

   assign pend_hit      = we_a_i && pend_q[waddr];
   assign msg_pending_o = pend_q;
`else
   assign pend_hit = 1'b0;
`endif

endmodule

// File: rtl/ibex_regfile_msg_burst_ff.sv
// Flip-flop register file with two read ports, a multi-word burst read port,
// one core write port and a burst message-ingress write port.
// Optional reservation scoreboard: define IBEX_REGFILE_MSG_SCOREBOARD_EN.
// Ports:
//   clk_i, rst_ni                    clock, synchronous active-low reset
//   raddr_a_i/rdata_a_o              read port A (combinational)
//   raddr_b_i/rdata_b_o              read port B (combinational)
//   rdata_burst_o                    MaxBurst words starting at raddr_a_i
//   waddr_a_i, wdata_a_i, we_a_i     core write port (priority over messages)
//   msg_valid_i, msg_ready_o         ingress handshake
//   msg_addr_i, msg_len_i, msg_data_i  ingress start/length/data
//   msg_busy_o, msg_done_o, err_o    ingress status
//   msg_pending_o                    reservation bitmap (scoreboard build only)
module ibex_regfile_msg_burst_ff
   import ibex_regfile_msg_pkg::*;
#(
   parameter bit                   RV32E       = 1'b0,
   parameter int unsigned          DataWidth   = 32,
   parameter int unsigned          MaxBurst    = 4,
   parameter logic [DataWidth-1:0] WordZeroVal = '0
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic [4:0]                        raddr_a_i,
   output logic [DataWidth-1:0]              rdata_a_o,
   input  logic [4:0]                        raddr_b_i,
   output logic [DataWidth-1:0]              rdata_b_o,
   output logic [MaxBurst*DataWidth-1:0]     rdata_burst_o,
   input  logic [4:0]                        waddr_a_i,
   input  logic [DataWidth-1:0]              wdata_a_i,
   input  logic                              we_a_i,
   input  logic                              msg_valid_i,
   output logic                              msg_ready_o,
   input  logic [4:0]                        msg_addr_i,
   input  logic [len_width(MaxBurst)-1:0]    msg_len_i,
   input  logic [DataWidth-1:0]              msg_data_i,
   output logic                              msg_busy_o,
   output logic                              msg_done_o,
   output logic                              err_o
`ifdef IBEX_REGFILE_MSG_SCOREBOARD_EN
   ,
   output logic [num_words(RV32E)-1:0]       msg_pending_o
`endif
);

   localparam int unsigned AW = addr_width(RV32E);
   localparam int unsigned NW = num_words(RV32E);

   logic [DataWidth-1:0] rf_q [NW];
   logic [NW-1:0]        msg_we;
   logic [DataWidth-1:0] msg_wdata;
   logic [AW-1:0]        waddr;
   logic [AW-1:0]        ra;
   logic [AW-1:0]        rb;

   assign waddr = waddr_a_i[AW-1:0];
   assign ra    = raddr_a_i[AW-1:0];
   assign rb    = raddr_b_i[AW-1:0];

   ibex_regfile_msg_seq #(
      .RV32E     (RV32E),
      .DataWidth (DataWidth),
      .MaxBurst  (MaxBurst)
   ) u_seq (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .we_a_i        (we_a_i),
      .waddr_a_i     (waddr_a_i),
      .msg_valid_i   (msg_valid_i),
      .msg_ready_o   (msg_ready_o),
      .msg_addr_i    (msg_addr_i),
      .msg_len_i     (msg_len_i),
      .msg_data_i    (msg_data_i),
      .msg_busy_o    (msg_busy_o),
      .msg_done_o    (msg_done_o),
      .err_o         (err_o),
      .msg_we_o      (msg_we),
      .msg_wdata_o   (msg_wdata)
`ifdef IBEX_REGFILE_MSG_SCOREBOARD_EN
      ,
      .msg_pending_o (msg_pending_o)
`endif
   );

   // Register array; x0 is only ever loaded by reset, and the sequencer never strobes it.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < NW; i++) begin
            rf_q[i] <= WordZeroVal;
         end
      end else begin
         for (int unsigned i = 0; i < NW; i++) begin
            if (we_a_i && (waddr == AW'(i)) && (i != 0)) begin
               rf_q[i] <= wdata_a_i;
            end else if (msg_we[i]) begin
               rf_q[i] <= msg_wdata;
            end
         end
      end
   end

   assign rdata_a_o = rf_q[ra];
   assign rdata_b_o = rf_q[rb];

   // Burst read wraps from the top register back to x0.
   always_comb begin
      rdata_burst_o = '0;
      for (int unsigned k = 0; k < MaxBurst; k++) begin
         rdata_burst_o[k*DataWidth +: DataWidth] = rf_q[ra + AW'(k)];
      end
   end

endmodule

// File: doc/ibex_regfile_msg_burst_ff.md
Name: ibex_regfile_msg_burst_ff

Overview:
Flip-flop register file with two architectural read ports, one core write port and a burst message-ingress port. The ingress port uses a valid/ready handshake and writes a message of 1..MaxBurst words into consecutive registers. A multi-word read port returns MaxBurst consecutive registers starting at raddr_a_i. It sits in the ID stage in place of the plain FF register file and is fed by the message-receive unit.

Parameters:
RV32E, 0, 1 = 16 registers (4-bit addr), 0 = 32 registers (5-bit addr)
DataWidth, 32, register word width
MaxBurst, 4, max message length in words; legal range 1..8
WordZeroVal, '0, reset value of every register and read value of x0

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
raddr_a_i  in  5  read address A
rdata_a_o  out  DataWidth  register[raddr_a_i]
raddr_b_i  in  5  read address B
rdata_b_o  out  DataWidth  register[raddr_b_i]
rdata_burst_o  out  MaxBurst*DataWidth  word k = register[(raddr_a_i+k) mod NUM_WORDS]
waddr_a_i  in  5  core write address
wdata_a_i  in  DataWidth  core write data
we_a_i  in  1  core write enable
msg_valid_i  in  1  ingress beat valid
msg_ready_o  out  1  ingress beat accepted when valid&&ready
msg_addr_i  in  5  start register; sampled on first beat only
msg_len_i  in  $clog2(MaxBurst)+1  length in words; sampled on first beat only
msg_data_i  in  DataWidth  beat data
msg_busy_o  out  1  burst in progress
msg_done_o  out  1  one-cycle pulse after the last beat is written
err_o  out  1  one-cycle pulse on a protocol error

Behaviour:
- Reset: rst_ni is synchronous. On the first clk_i edge with rst_ni low:
  - all registers are loaded with WordZeroVal;
  - the FSM goes to IDLE;
  - msg_busy_o, msg_done_o and err_o go to 0;
  - msg_ready_o reads 1 in IDLE whenever no stall applies.
- Reset mid-burst: the burst is abandoned; no done pulse is generated; words already written are overwritten by the reset value.
- x0: always reads WordZeroVal. Writes to x0 from either port are dropped, but a message beat aimed at x0 still counts toward the length.
- Reads: combinational and zero latency. Core and message writes become visible the cycle after their write edge; there is no write-to-read bypass.
- FSM states: IDLE, BURST.
  - IDLE, accepted beat: msg_addr_i and msg_len_i are captured; the beat writes register msg_addr_i.
    - len 1: stay in IDLE; msg_done_o pulses next cycle.
    - len >= 2: go to BURST with ptr = addr+1 and remaining = len-1.
  - BURST, accepted beat: writes register ptr; ptr increments mod NUM_WORDS (wrap from top register to x0); remaining decrements. When remaining reaches 0: back to IDLE and msg_done_o pulses next cycle.
  - BURST with msg_valid_i low: hold state; beats may be spaced arbitrarily.
  - msg_busy_o = (state == BURST).
- Length errors: msg_len_i == 0 or msg_len_i > MaxBurst on a first beat:
  - the beat is accepted and dropped;
  - err_o pulses next cycle;
  - the FSM stays in IDLE.
- Address range: when RV32E = 1, bit 4 of every address is ignored.
- Write conflicts: a core write has priority.
  - msg_ready_o = 0 when we_a_i is high and waddr_a_i equals the current target (msg_addr_i in IDLE, ptr in BURST), unless that target is x0.
  - Consequence: the beat stalls one cycle and the core value is written.
  - Writes to different registers in the same cycle both take effect.
- msg_ready_o depends combinationally only on state, we_a_i, waddr_a_i and msg_addr_i/ptr. It never depends on msg_valid_i.
- Back-to-back: a first beat of a new message may be accepted in the same cycle msg_done_o pulses for the previous one.

Optional Feature:
IBEX_REGFILE_MSG_SCOREBOARD_EN.
- Defined:
  - adds output msg_pending_o (width NUM_WORDS); bit i is set while register i is reserved by an in-flight burst;
  - all bits for the burst are set when the first beat is accepted, and each bit clears when its beat is written;
  - a core write (we_a_i) to a pending register pulses err_o, and the write still takes effect.
- Undefined: the port is absent and no scoreboard flops exist.

Decomposition:
- Package ibex_regfile_msg_pkg holds:
  - the msg_state_e enum (IDLE, BURST);
  - the localparam functions for address width and length width;
  - the error-cause constants.
- Sub-module ibex_regfile_msg_seq: ingress FSM, ptr/remaining counters and ready/conflict logic. It outputs a one-hot write strobe plus data.
- The top level contains the register flops and the read muxes.

Test Plan:
1. Reset, then read x1 and x31 -> rdata == WordZeroVal; msg_ready_o = 1; msg_busy_o = 0.
2. Message addr = 5, len = 3, data A,B,C with gaps of 0/2/0 idle cycles -> x5..x7 = A,B,C; msg_done_o pulses exactly once, the cycle after C; rdata_burst_o at raddr 5 = {…,C,B,A}.
3. Message addr = 30, len = 4 (RV32E = 0) -> x30 = D0, x31 = D1, x0 still reads 0, x1 = D3; done asserts after 4 beats.
4. BURST with ptr = 9, core we_a_i to x9 with value 0x1234 in the same cycle as beat 0xBEEF -> msg_ready_o = 0 that cycle; next cycle the beat is accepted; x9 = 0xBEEF.
5. First beat with msg_len_i = 0, then with msg_len_i = MaxBurst+1 -> err_o pulses each time; no register changes; FSM stays in IDLE.
6. rst_ni low during beat 2 of a len = 4 burst -> next cycle all registers = WordZeroVal, msg_busy_o = 0, no msg_done_o; a fresh message then completes normally.
